// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED chase-fade sequencer: FSM state encoding
// and a constant-evaluable ceiling-log2 helper for sizing index registers.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  // Ceiling log2; clog2(1) == 0, clog2(4) == 2, clog2(5) == 3.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_seq_tick_gen.sv
// Step-rate prescaler for the fade sequencer. Free-runs over 0..2^DIV_LEN-1
// while not cleared and flags the terminal count as a one-cycle tick; the
// counter wraps naturally at all-ones. Clear holds the count at zero and
// masks the tick.
module led_seq_tick_gen #(
  parameter int DIV_LEN = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  logic [DIV_LEN-1:0] cnt_q;

  // Prescaler count: held at zero when cleared, otherwise increments and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_LEN'(1);
    end
  end

  assign tick_o = !clr_i && (cnt_q == '1);

endmodule

// File: rtl/led_fade_sequencer.sv
// Single-channel chase-fade sequencer driving the compare inputs of a pwm_1
// array. The active channel ramps 0->MAX, holds HOLD_TICKS steps, ramps back
// to 0, then the next channel takes over. All outputs are registered.
// Optional build macro: LED_FADE_SEQ_LOOP_EN -- when defined the sequence
// wraps from the last channel back to channel 0 and runs until stop; when
// undefined it returns to IDLE with a one-cycle done pulse.
module led_fade_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int CTR_LEN    = 3,
  parameter int DIV_LEN    = 22,
  parameter int HOLD_TICKS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  output logic                           busy,
  output logic                           done,
  output logic [clog2(NUM_CH)-1:0]       active_ch,
  output logic [NUM_CH*CTR_LEN-1:0]      compare_bus
);

  localparam int CH_W      = clog2(NUM_CH);
  localparam int HOLD_W    = (HOLD_TICKS > 0) ? clog2(HOLD_TICKS + 1) : 1;
  localparam int HOLD_LAST = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;
  localparam logic [CTR_LEN-1:0] LVL_MAX = '1;
  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(NUM_CH - 1);

  // Level steps saturate at the ends so a stray tick can never wrap the LED.
  function automatic logic [CTR_LEN-1:0] sat_inc(input logic [CTR_LEN-1:0] lvl);
    return (lvl == LVL_MAX) ? LVL_MAX : lvl + CTR_LEN'(1);
  endfunction

  function automatic logic [CTR_LEN-1:0] sat_dec(input logic [CTR_LEN-1:0] lvl);
    return (lvl == '0) ? '0 : lvl - CTR_LEN'(1);
  endfunction

  state_e                    state_q, state_d;
  logic [CTR_LEN-1:0]        level_q, level_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [NUM_CH*CTR_LEN-1:0] cmp_q, cmp_d;

  logic accept;
  logic tick;
  logic presc_clr;

  // A start is taken only from IDLE and only when stop is not also asserted.
  assign accept    = (state_q == ST_IDLE) && start && !stop;
  // The prescaler runs from the accepting cycle onward so the first step lands
  // exactly 2^DIV_LEN cycles later; it is parked at zero whenever idle or stopping.
  assign presc_clr = !(busy_q || accept) || stop;

  led_seq_tick_gen #(
    .DIV_LEN (DIV_LEN)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  // Next-state logic: FSM transitions, level/hold/channel updates, compare bus image.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    ch_d    = ch_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cmp_d   = '0;

    if (stop) begin
      state_d = ST_IDLE;
      level_d = '0;
      hold_d  = '0;
      ch_d    = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RAMP_UP;
            level_d = '0;
            hold_d  = '0;
            ch_d    = '0;
            busy_d  = 1'b1;
          end
        end

        ST_RAMP_UP: begin
          if (tick) begin
            level_d = sat_inc(level_q);
            if (level_d == LVL_MAX) begin
              hold_d  = '0;
              state_d = (HOLD_TICKS > 0) ? ST_HOLD : ST_RAMP_DOWN;
            end
          end
        end

        ST_HOLD: begin
          if (tick) begin
            if (hold_q == HOLD_W'(HOLD_LAST)) begin
              hold_d  = '0;
              state_d = ST_RAMP_DOWN;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end

        ST_RAMP_DOWN: begin
          if (tick) begin
            level_d = sat_dec(level_q);
            if (level_d == '0) begin
              if (ch_q != CH_LAST) begin
                ch_d    = ch_q + CH_W'(1);
                state_d = ST_RAMP_UP;
              end else begin
`ifdef LED_FADE_SEQ_LOOP_EN
                ch_d    = '0;
                state_d = ST_RAMP_UP;
`else
                ch_d    = '0;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`endif
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          level_d = '0;
          hold_d  = '0;
          ch_d    = '0;
          busy_d  = 1'b0;
        end
      endcase
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_d == CH_W'(i)) begin
        cmp_d[i*CTR_LEN +: CTR_LEN] = level_d;
      end
    end
  end

  // State and output registers; reset returns everything to the idle image at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      hold_q  <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cmp_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cmp_q   <= cmp_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign active_ch   = ch_q;
  assign compare_bus = cmp_q;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Directed bench for led_fade_sequencer with NUM_CH=4, CTR_LEN=3, DIV_LEN=2,
// HOLD_TICKS=2: a step tick every 4 cycles and 16 ticks per channel.
// Cycle n below is the value observed after the (n-1)th edge following the
// edge that accepts start (that edge is cycle 0).
module tb_led_fade_sequencer;

  localparam int NUM_CH     = 4;
  localparam int CTR_LEN    = 3;
  localparam int DIV_LEN    = 2;
  localparam int HOLD_TICKS = 2;

`ifdef LED_FADE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        busy;
  logic        done;
  logic [1:0]  active_ch;
  logic [11:0] compare_bus;

  int n_pass   = 0;
  int n_total  = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int exp_done_runs;

  always #5 clk = ~clk;

  led_fade_sequencer #(
    .NUM_CH     (NUM_CH),
    .CTR_LEN    (CTR_LEN),
    .DIV_LEN    (DIV_LEN),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .done        (done),
    .active_ch   (active_ch),
    .compare_bus (compare_bus)
  );

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc   = 1;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_done_runs = LOOP ? 0 : 1;

    // Reset state before any clock edge.
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ch",   active_ch, 0);
    chk("rst_bus",  compare_bus, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run A: timing of the first channel, start ignored while busy, full run.
    launch();
    chk("A_busy_c1", busy, 1);
    chk("A_bus_c1",  compare_bus, 0);
    go_to(4);
    chk("A_bus_c4",  compare_bus, 1);
    chk("A_ch_c4",   active_ch, 0);
    go_to(9);
    start = 1'b1;
    go_to(10);
    start = 1'b0;
    go_to(12);
    chk("A_bus_c12_start_ignored", compare_bus, 3);
    go_to(28);
    chk("A_bus_c28", compare_bus, 7);
    go_to(36);
    chk("A_bus_c36", compare_bus, 7);
    go_to(40);
    chk("A_bus_c40", compare_bus, 6);
    go_to(64);
    chk("A_bus_c64", compare_bus, 0);
    chk("A_ch_c64",  active_ch, 1);
    go_to(68);
    chk("A_bus_c68", compare_bus, 8);
    go_to(252);
    chk("A_bus_c252", compare_bus, 512);
    chk("A_ch_c252",  active_ch, 3);
    chk("A_done_c252", done, 0);
    go_to(256);
    chk("A_busy_c256", busy, LOOP ? 1 : 0);
    chk("A_done_c256", done, LOOP ? 0 : 1);
    chk("A_ch_c256",   active_ch, 0);
    chk("A_bus_c256",  compare_bus, 0);
    go_to(257);
    chk("A_done_c257", done, 0);
    go_to(260);
    chk("A_bus_c260", compare_bus, LOOP ? 1 : 0);
    chk("A_done_pulses", done_cnt, exp_done_runs);
    stop = 1'b1;
    go_to(261);
    stop = 1'b0;
    chk("A_busy_after_stop", busy, 0);
    chk("A_bus_after_stop",  compare_bus, 0);

    // start and stop together in IDLE: stop wins.
    go_to(263);
    start = 1'b1;
    stop  = 1'b1;
    go_to(264);
    start = 1'b0;
    stop  = 1'b0;
    chk("SS_busy", busy, 0);
    go_to(270);
    chk("SS_busy_later", busy, 0);
    chk("SS_bus_later",  compare_bus, 0);

    // Run B: stop while channel 1 is active.
    launch();
    go_to(100);
    chk("B_ch_c100",   active_ch, 1);
    chk("B_bus_c100",  compare_bus, 56);
    chk("B_busy_c100", busy, 1);
    stop = 1'b1;
    go_to(101);
    stop = 1'b0;
    chk("B_busy_stop", busy, 0);
    chk("B_bus_stop",  compare_bus, 0);
    chk("B_ch_stop",   active_ch, 0);
    chk("B_done_stop", done, 0);
    go_to(110);
    chk("B_done_pulses", done_cnt, exp_done_runs);
    chk("B_bus_idle",    compare_bus, 0);

    // Run C: asynchronous reset mid-sequence, away from any clock edge.
    launch();
    go_to(30);
    chk("C_bus_c30", compare_bus, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("C_rst_busy", busy, 0);
    chk("C_rst_done", done, 0);
    chk("C_rst_ch",   active_ch, 0);
    chk("C_rst_bus",  compare_bus, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("C_busy_after_rst", busy, 0);
    chk("C_done_pulses",    done_cnt, exp_done_runs);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
